cdb_arbiter: RTL and testbench

//  Collects completed results from the ALU, MULT and LOAD functional units and broadcasts up to
//  CDB_WIDTH of them per cycle on the common data bus.
//  The CDB feeds the reservation-station wakeup logic, the ROB and the physical register file.

---
 rtl/cdb_arbiter.sv | 117 +++++++++++
 tb/tb_cdb_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per functional-unit result source,
// round-robin selection of up to CDB_WIDTH held results for broadcast each cycle.
package cdb_pkg;
    localparam int PRN_WIDTH = 6;

    typedef struct packed {
        logic                 valid;
        logic [PRN_WIDTH-1:0] dest_prn;
        logic [31:0]          value;
    } cdb_packet_t;
endpackage

module cdb_arbiter #(
    parameter  int NUM_SRC   = 4,
    parameter  int CDB_WIDTH = 2,
    localparam int PTR_W     = $clog2(NUM_SRC),
    localparam int PRN_WIDTH = cdb_pkg::PRN_WIDTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  squash,
    input  logic [NUM_SRC-1:0]                    fu_done_valid,
    input  logic [NUM_SRC-1:0][PRN_WIDTH-1:0]     fu_done_prn,
    input  logic [NUM_SRC-1:0][31:0]              fu_done_value,
    output logic [NUM_SRC-1:0]                    fu_avail,
    output cdb_pkg::cdb_packet_t [CDB_WIDTH-1:0]  cdb_packet,
    output logic [PTR_W:0]                        held_cnt
);

    logic [NUM_SRC-1:0]   hold_valid_reg;
    logic [NUM_SRC-1:0]   hold_valid_next;
    logic [PRN_WIDTH-1:0] hold_prn_reg   [NUM_SRC];
    logic [31:0]          hold_value_reg [NUM_SRC];
    logic [PTR_W-1:0]     rr_ptr_reg;
    logic [PTR_W-1:0]     rr_next;

    logic [NUM_SRC-1:0]   granted;
    logic [NUM_SRC-1:0]   capture;

    int                   lane;
    logic [PTR_W:0]       scan_sum;
    logic [PTR_W-1:0]     scan_src;

    // Walk sources from rr_ptr with wrap; the k-th held source found drives lane k.
    always_comb begin
        granted    = '0;
        cdb_packet = '0;
        rr_next    = rr_ptr_reg;
        lane       = 0;
        scan_sum   = '0;
        scan_src   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(NUM_SRC)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_SRC);
            end
            scan_src = scan_sum[PTR_W-1:0];
            if (hold_valid_reg[scan_src] && (lane < CDB_WIDTH)) begin
                granted[scan_src] = 1'b1;
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (lane == k) begin
                        cdb_packet[k].valid    = 1'b1;
                        cdb_packet[k].dest_prn = hold_prn_reg[scan_src];
                        cdb_packet[k].value    = hold_value_reg[scan_src];
                    end
                end
                rr_next = (scan_src == PTR_W'(NUM_SRC-1)) ? '0 : scan_src + 1'b1;
                lane    = lane + 1;
            end
        end
        // A flush cycle must not wake up any consumer with a doomed result.
        if (squash) begin
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_packet[k].valid = 1'b0;
            end
        end
    end

    assign fu_avail = squash ? '0 : (~hold_valid_reg | granted);

    // Capture wins over drain, so a granted slot can be refilled on the same edge.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
        assign capture[gi]         = fu_done_valid[gi] & fu_avail[gi];
        assign hold_valid_next[gi] = capture[gi] | (hold_valid_reg[gi] & ~granted[gi]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid_reg <= '0;
            rr_ptr_reg     <= '0;
        end else if (squash) begin
            hold_valid_reg <= '0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            if (|granted) begin
                rr_ptr_reg <= rr_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (capture[i]) begin
                hold_prn_reg[i]   <= fu_done_prn[i];
                hold_value_reg[i] <= fu_done_value[i];
            end
        end
    end

    always_comb begin
        held_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            held_cnt = held_cnt + (PTR_W+1)'(hold_valid_reg[i]);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with NUM_SRC=4, CDB_WIDTH=2; expected bus contents hand-derived.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NUM_SRC   = 4;
    localparam int CDB_WIDTH = 2;

    logic                             clk;
    logic                             reset;
    logic                             squash;
    logic [NUM_SRC-1:0]               fu_done_valid;
    logic [NUM_SRC-1:0][PRN_WIDTH-1:0] fu_done_prn;
    logic [NUM_SRC-1:0][31:0]         fu_done_value;
    logic [NUM_SRC-1:0]               fu_avail;
    cdb_packet_t [CDB_WIDTH-1:0]      cdb_packet;
    logic [2:0]                       held_cnt;

    int n_cmp;
    int n_bad;

    cdb_packet_t e0, e1;
    logic [3:0]  ea;
    logic [2:0]  eh;

    cdb_arbiter #(.NUM_SRC(NUM_SRC), .CDB_WIDTH(CDB_WIDTH)) dut (
        .clock         (clk),
        .reset         (reset),
        .squash        (squash),
        .fu_done_valid (fu_done_valid),
        .fu_done_prn   (fu_done_prn),
        .fu_done_value (fu_done_value),
        .fu_avail      (fu_avail),
        .cdb_packet    (cdb_packet),
        .held_cnt      (held_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lanes with valid=0 carry don't-care payload, so compare them as all-zero.
    function automatic cdb_packet_t norm(input cdb_packet_t p);
        return p.valid ? p : '0;
    endfunction

    function automatic cdb_packet_t pk(input int prn, input logic [31:0] val);
        cdb_packet_t p;
        p.valid    = 1'b1;
        p.dest_prn = PRN_WIDTH'(prn);
        p.value    = val;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        fu_done_valid = '0;
    endtask

    task automatic drive(input int j, input int prn, input logic [31:0] val);
        fu_done_valid[j] = 1'b1;
        fu_done_prn[j]   = PRN_WIDTH'(prn);
        fu_done_value[j] = val;
    endtask

    task automatic expect_state(input cdb_packet_t x0, input cdb_packet_t x1,
                                input logic [3:0] xa, input logic [2:0] xh);
        e0 = x0; e1 = x1; ea = xa; eh = xh;
    endtask

    task automatic test_reset();
        reset = 1'b1; squash = 1'b0; idle();
        fu_done_prn = '0; fu_done_value = '0;
        repeat (3) tick();
        reset = 1'b0;
        settle();
        expect_state('0, '0, 4'b1111, 3'd0);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL reset: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
    endtask

    task automatic test_single();
        drive(0, 5, 32'hDEAD);
        settle();
        n_cmp++;
        if (fu_avail !== 4'b1111 || cdb_packet[0].valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pre: got avail=%b l0v=%b exp avail=1111 l0v=0", fu_avail, cdb_packet[0].valid);
        end
        tick(); idle(); settle();
        expect_state(pk(5, 32'hDEAD), '0, 4'b1111, 3'd1);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL single_t1: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
        expect_state('0, '0, 4'b1111, 3'd0);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL single_t2: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        // rr_ptr is 1 now; a lone src3 grant brings it back to 0.
        drive(3, 7, 32'h33);
        tick(); idle(); settle();
        expect_state(pk(7, 32'h33), '0, 4'b1111, 3'd1);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL single_src3: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
    endtask

    task automatic test_all_four();
        for (int j = 0; j < NUM_SRC; j++) drive(j, j + 1, 32'h100 + j);
        tick(); idle(); settle();
        expect_state(pk(1, 32'h100), pk(2, 32'h101), 4'b0011, 3'd4);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL all4_c1: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
        expect_state(pk(3, 32'h102), pk(4, 32'h103), 4'b1111, 3'd2);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL all4_c2: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
        // With rr_ptr back at 0, src0 must take lane 0 ahead of src3.
        drive(3, 8, 32'h203);
        drive(0, 9, 32'h200);
        tick(); idle(); settle();
        expect_state(pk(9, 32'h200), pk(8, 32'h203), 4'b1111, 3'd2);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL all4_rr0: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
    endtask

    task automatic test_wrap();
        drive(2, 10, 32'h302);
        tick(); idle(); settle();
        expect_state(pk(10, 32'h302), '0, 4'b1111, 3'd1);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL wrap_prep: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
        drive(3, 11, 32'h403);
        drive(0, 12, 32'h400);
        tick(); idle(); settle();
        expect_state(pk(11, 32'h403), pk(12, 32'h400), 4'b1111, 3'd2);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL wrap_lanes: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
        // rr_ptr should now be 1: src1, src2 go first and src0 waits.
        drive(0, 13, 32'h500);
        drive(1, 14, 32'h501);
        drive(2, 15, 32'h502);
        tick(); idle(); settle();
        expect_state(pk(14, 32'h501), pk(15, 32'h502), 4'b1110, 3'd3);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL wrap_rr1: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
        expect_state(pk(13, 32'h500), '0, 4'b1111, 3'd1);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL wrap_tail: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
    endtask

    task automatic test_refill();
        drive(1, 16, 32'h600);
        tick(); idle();
        drive(1, 9, 32'h42);
        settle();
        expect_state(pk(16, 32'h600), '0, 4'b1111, 3'd1);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL refill_drain: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick(); idle(); settle();
        expect_state(pk(9, 32'h42), '0, 4'b1111, 3'd1);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL refill_next: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
    endtask

    task automatic test_stall();
        // rr_ptr is 2 here.
        for (int j = 0; j < NUM_SRC; j++) drive(j, 20 + j, 32'h700 + j);
        tick(); idle();
        drive(0, 30, 32'hBAD);
        settle();
        expect_state(pk(22, 32'h702), pk(23, 32'h703), 4'b1100, 3'd4);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL stall_c1: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick(); idle(); settle();
        expect_state(pk(20, 32'h700), pk(21, 32'h701), 4'b1111, 3'd2);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL stall_c2: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
    endtask

    task automatic test_zero_prn();
        drive(1, 0, 32'h900);
        tick(); idle(); settle();
        expect_state(pk(0, 32'h900), '0, 4'b1111, 3'd1);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL zero_prn: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
    endtask

    task automatic test_squash();
        drive(0, 40, 32'h800);
        drive(1, 41, 32'h801);
        drive(2, 42, 32'h802);
        tick(); idle();
        squash = 1'b1;
        drive(3, 43, 32'h803);
        settle();
        n_cmp++;
        if ({cdb_packet[1].valid, cdb_packet[0].valid, fu_avail, held_cnt} !== {2'b00, 4'b0000, 3'd3}) begin
            n_bad++;
            $display("FAIL squash_cycle: got v1=%b v0=%b avail=%b held=%0d exp v1=0 v0=0 avail=0000 held=3",
                     cdb_packet[1].valid, cdb_packet[0].valid, fu_avail, held_cnt);
        end
        tick();
        squash = 1'b0; idle(); settle();
        expect_state('0, '0, 4'b1111, 3'd0);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL squash_after: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
        // rr_ptr survives the flush at 2, so src2 leads src1.
        drive(1, 50, 32'hA01);
        drive(2, 51, 32'hA02);
        tick(); idle(); settle();
        expect_state(pk(51, 32'hA02), pk(50, 32'hA01), 4'b1111, 3'd2);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL squash_rr_kept: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(0, 60, 32'hB00);
        drive(1, 61, 32'hB01);
        drive(2, 62, 32'hB02);
        tick(); idle();
        reset = 1'b1;
        tick();
        reset = 1'b0; settle();
        expect_state('0, '0, 4'b1111, 3'd0);
        n_cmp++;
        if ({norm(cdb_packet[1]), norm(cdb_packet[0]), fu_avail, held_cnt} !== {e1, e0, ea, eh}) begin
            n_bad++;
            $display("FAIL reset_mid: got l0=%h l1=%h avail=%b held=%0d exp l0=%h l1=%h avail=%b held=%0d",
                     cdb_packet[0], cdb_packet[1], fu_avail, held_cnt, e0, e1, ea, eh);
        end
        tick();
        n_cmp++;
        if ({cdb_packet[1].valid, cdb_packet[0].valid, held_cnt} !== {2'b00, 3'd0}) begin
            n_bad++;
            $display("FAIL reset_mid_after: got v1=%b v0=%b held=%0d exp v1=0 v0=0 held=0",
                     cdb_packet[1].valid, cdb_packet[0].valid, held_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_refill();
        test_stall();
        test_zero_prn();
        test_squash();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
